// File: rtl/sample_mux_pkg.sv
// Shared definitions for sample_mux: FSM state encodings and default parameter values.
package sample_mux_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FADE = 1'b1
  } state_t;

  localparam int DEF_WIDTH     = 24;
  localparam int DEF_CHANNELS  = 4;
  localparam int DEF_RAMP_LOG2 = 4;

endpackage

// File: rtl/sample_mux_xfade_lerp.sv
// xfade_lerp: combinational signed interpolator y = a + ((b - a) * s >>> RAMP_LOG2).
// Floor rounding; the result always lies between a and b, so the WIDTH-bit result is exact.
module xfade_lerp
  import sample_mux_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int RAMP_LOG2 = DEF_RAMP_LOG2
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic        [RAMP_LOG2:0] s,
  output logic signed [WIDTH-1:0] y
);

  localparam int PW = WIDTH + RAMP_LOG2 + 2;

  logic signed [WIDTH:0]  diff;
  logic signed [PW-1:0]   diff_x;
  logic signed [PW-1:0]   s_x;
  logic signed [PW-1:0]   a_x;
  logic signed [PW-1:0]   prod;

  assign diff   = $signed({b[WIDTH-1], b}) - $signed({a[WIDTH-1], a});
  assign diff_x = {{(PW-WIDTH-1){diff[WIDTH]}}, diff};
  // s is an unsigned step count; zero-extend so it stays non-negative in the signed product.
  assign s_x    = {{(PW-RAMP_LOG2-1){1'b0}}, s};
  assign a_x    = {{(PW-WIDTH){a[WIDTH-1]}}, a};
  assign prod   = diff_x * s_x;
  assign y      = WIDTH'(a_x + (prod >>> RAMP_LOG2));

endmodule

// File: rtl/sample_mux.sv
// sample_mux: registered N-channel signed sample selector, one channel forwarded per strobe.
// Define SAMPLE_MUX_XFADE_EN to replace the hard switch with a 2^RAMP_LOG2-sample linear crossfade.
module sample_mux
  import sample_mux_pkg::*;
#(
  parameter  int WIDTH     = DEF_WIDTH,
  parameter  int CHANNELS  = DEF_CHANNELS,
  parameter  int RAMP_LOG2 = DEF_RAMP_LOG2,
  localparam int SELW      = $clog2(CHANNELS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS*WIDTH-1:0]    in_data,
  input  logic                         in_valid,
  input  logic [SELW-1:0]              sel,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  output logic                         busy
);

  localparam logic [SELW:0] CHAN_LIMIT = (SELW+1)'(CHANNELS);

  logic signed [WIDTH-1:0] chan [CHANNELS];

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
    assign chan[gi] = in_data[gi*WIDTH +: WIDTH];
  end

  logic [SELW-1:0]         cur_reg, cur_next;
  logic [SELW-1:0]         sel_eff;
  logic signed [WIDTH-1:0] out_data_reg, out_data_next;
  logic                    out_valid_reg, out_valid_next;

  // Out-of-range requests collapse to the current channel, i.e. "no change".
  assign sel_eff = ({1'b0, sel} < CHAN_LIMIT) ? sel : cur_reg;

`ifdef SAMPLE_MUX_XFADE_EN
  localparam int STEPW = RAMP_LOG2 + 1;
  localparam logic [STEPW-1:0] STEP_ONE = STEPW'(1);
  localparam logic [STEPW-1:0] FADE_END = STEPW'(2**RAMP_LOG2);

  state_t                  state_reg, state_next;
  logic [SELW-1:0]         tgt_reg, tgt_next;
  logic [STEPW-1:0]        step_reg, step_next;
  logic                    busy_reg, busy_next;
  logic [STEPW-1:0]        step_inc;
  logic signed [WIDTH-1:0] lerp_b;
  logic [STEPW-1:0]        lerp_s;
  logic signed [WIDTH-1:0] lerp_y;

  assign step_inc = step_reg + STEP_ONE;
  // In IDLE the lerp pre-computes the first fade sample towards the requested channel.
  assign lerp_b   = (state_reg == ST_FADE) ? chan[tgt_reg] : chan[sel_eff];
  assign lerp_s   = (state_reg == ST_FADE) ? step_inc : STEP_ONE;

  xfade_lerp #(
    .WIDTH     (WIDTH),
    .RAMP_LOG2 (RAMP_LOG2)
  ) u_lerp (
    .a (chan[cur_reg]),
    .b (lerp_b),
    .s (lerp_s),
    .y (lerp_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cur_reg       <= '0;
      tgt_reg       <= '0;
      step_reg      <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cur_reg       <= cur_next;
      tgt_reg       <= tgt_next;
      step_reg      <= step_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      busy_reg      <= busy_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cur_next       = cur_reg;
    tgt_next       = tgt_reg;
    step_next      = step_reg;
    out_data_next  = out_data_reg;
    out_valid_next = 1'b0;
    busy_next      = busy_reg;
    if (in_valid) begin
      out_valid_next = 1'b1;
      case (state_reg)
        ST_IDLE: begin
          if (sel_eff != cur_reg) begin
            tgt_next      = sel_eff;
            step_next     = STEP_ONE;
            out_data_next = lerp_y;
            state_next    = ST_FADE;
            busy_next     = 1'b1;
          end else begin
            out_data_next = chan[cur_reg];
            busy_next     = 1'b0;
          end
        end
        ST_FADE: begin
          step_next     = step_inc;
          out_data_next = lerp_y;
          busy_next     = 1'b1;
          // Last ramp sample equals in[tgt] exactly, so the handover is seamless.
          if (step_inc == FADE_END) begin
            cur_next   = tgt_reg;
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign busy = busy_reg;
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_reg       <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      cur_reg       <= cur_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
    end
  end

  always_comb begin
    cur_next       = cur_reg;
    out_data_next  = out_data_reg;
    out_valid_next = 1'b0;
    if (in_valid) begin
      cur_next       = sel_eff;
      out_data_next  = chan[sel_eff];
      out_valid_next = 1'b1;
    end
  end

  // Hard-switch build never fades; RAMP_LOG2 only shapes the fade, so busy is constant 0.
  assign busy = (RAMP_LOG2 < 0);
`endif

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_sample_mux.sv
// Directed self-checking bench for sample_mux; expectations follow SAMPLE_MUX_XFADE_EN when defined.
module tb_sample_mux;

  logic        clk = 1'b0;
  logic        reset;

  // Instance A: WIDTH=8, CHANNELS=5 (so sel=5..7 is out of range), RAMP_LOG2=2
  logic [39:0] in_data_a;
  logic        in_valid_a;
  logic [2:0]  sel_a;
  logic [7:0]  out_data_a;
  logic        out_valid_a;
  logic        busy_a;

  // Instance B: WIDTH=24, CHANNELS=4, RAMP_LOG2=4 (full-scale ramp)
  logic [95:0] in_data_b;
  logic        in_valid_b;
  logic [1:0]  sel_b;
  logic [23:0] out_data_b;
  logic        out_valid_b;
  logic        busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sample_mux #(.WIDTH(8), .CHANNELS(5), .RAMP_LOG2(2)) u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data_a),
    .in_valid  (in_valid_a),
    .sel       (sel_a),
    .out_data  (out_data_a),
    .out_valid (out_valid_a),
    .busy      (busy_a)
  );

  sample_mux #(.WIDTH(24), .CHANNELS(4), .RAMP_LOG2(4)) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data_b),
    .in_valid  (in_valid_b),
    .sel       (sel_b),
    .out_data  (out_data_b),
    .out_valid (out_valid_b),
    .busy      (busy_b)
  );

  task automatic check(input string tag, input longint got, input longint expected);
    n_checks++;
    if (got !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expected);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic set_a(input int c0, input int c1, input int c2, input int c3, input int c4);
    in_data_a = {8'(c4), 8'(c3), 8'(c2), 8'(c1), 8'(c0)};
  endtask

  // One clock with the given strobe on A, then check data/valid/busy 1 time unit after the edge.
  task automatic xa(input string tag, input int s, input bit v,
                    input int e_data, input bit e_valid, input bit e_busy);
    sel_a      = 3'(s);
    in_valid_a = v;
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    check({tag, ".data"}, $signed(out_data_a), e_data);
    check({tag, ".valid"}, out_valid_a, e_valid);
    check({tag, ".busy"}, busy_a, e_busy);
  endtask

  task automatic drive_b(input int s, input bit v);
    sel_b      = 2'(s);
    in_valid_b = v;
    @(posedge clk);
    #1;
    in_valid_b = 1'b0;
  endtask

  initial begin
    longint prev;
    int     fs_exp [int];
    reset      = 1'b1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    sel_a      = '0;
    sel_b      = '0;
    set_a(0, 0, 0, 0, 0);
    in_data_b  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a.data", $signed(out_data_a), 0);
    check("rst_a.valid", out_valid_a, 0);
    check("rst_a.busy", busy_a, 0);
    check("rst_b.data", $signed(out_data_b), 0);
    check("rst_b.busy", busy_b, 0);
    reset = 1'b0;

    // Full-scale swing on B, ch0 = most negative, ch1 = most positive
    in_data_b = {24'd0, 24'd0, 24'sd8388607, -24'sd8388608};
    drive_b(0, 1'b1);
    check("fs_start", $signed(out_data_b), -8388608);
`ifdef SAMPLE_MUX_XFADE_EN
    fs_exp[1]  = -7340033;
    fs_exp[8]  = -1;
    fs_exp[16] = 8388607;
    prev = -8388608;
    for (int s = 1; s <= 16; s++) begin
      drive_b(1, 1'b1);
      check($sformatf("fs_mono%0d", s), ($signed(out_data_b) > prev) ? 1 : 0, 1);
      check($sformatf("fs_busy%0d", s), busy_b, 1);
      if (fs_exp.exists(s)) check($sformatf("fs_val%0d", s), $signed(out_data_b), fs_exp[s]);
      prev = $signed(out_data_b);
    end
    drive_b(1, 1'b1);
    check("fs_idle.data", $signed(out_data_b), 8388607);
    check("fs_idle.busy", busy_b, 0);
`else
    drive_b(1, 1'b1);
    check("fs_switch", $signed(out_data_b), 8388607);
    check("fs_switch.busy", busy_b, 0);
`endif

`ifdef SAMPLE_MUX_XFADE_EN
    // Fade up -100 -> 100 over 4 samples
    set_a(-100, 100, 20, 0, 0);
    xa("up0",  0, 1, -100, 1, 0);
    xa("up1",  1, 1,  -50, 1, 1);
    xa("up2",  1, 1,    0, 1, 1);
    xa("up3",  1, 1,   50, 1, 1);
    xa("up4",  1, 1,  100, 1, 1);
    xa("up_idle", 1, 1, 100, 1, 0);
    xa("gap0", 0, 0,  100, 0, 0);
    // Fade down to ch0; sel=2 mid-fade is ignored until the fade ends
    xa("dn1",  0, 1,   50, 1, 1);
    xa("dn2",  2, 1,    0, 1, 1);
    xa("dn3",  2, 1,  -50, 1, 1);
    xa("dn4",  2, 1, -100, 1, 1);
    // Pending sel=2 now starts a new fade 0 -> 2, with a strobe gap and a live input change
    xa("re1",  2, 1,  -70, 1, 1);
    xa("re_gap", 2, 0, -70, 0, 1);
    xa("re2",  2, 1,  -40, 1, 1);
    set_a(-100, 100, 60, 0, 0);
    xa("re3",  2, 1,   20, 1, 1);
    xa("re4",  2, 1,   60, 1, 1);
    // Out-of-range selects are "no change"
    xa("oor5", 5, 1,   60, 1, 0);
    xa("oor7", 7, 1,   60, 1, 0);
    // Reset on the second fade sample aborts the fade
    xa("ab1",  0, 1,   20, 1, 1);
    reset = 1'b1; sel_a = 3'd0; in_valid_a = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; in_valid_a = 1'b0;
    check("ab_rst.data", $signed(out_data_a), 0);
    check("ab_rst.valid", out_valid_a, 0);
    check("ab_rst.busy", busy_a, 0);
    xa("ab_after", 0, 1, -100, 1, 0);
    // Floor rounding 3 -> -2
    set_a(3, -2, 0, 0, 0);
    xa("fl0",  0, 1,    3, 1, 0);
    xa("fl1",  1, 1,    1, 1, 1);
    xa("fl2",  1, 1,    0, 1, 1);
    xa("fl3",  1, 1,   -1, 1, 1);
    xa("fl4",  1, 1,   -2, 1, 1);
    xa("fl_idle", 1, 1, -2, 1, 0);
`else
    set_a(-2, 3, 50, 0, 0);
    xa("hs0",  0, 1,   -2, 1, 0);
    xa("hs1",  1, 1,    3, 1, 0);
    xa("gap0", 0, 0,    3, 0, 0);
    xa("hs_hold", 1, 1, 3, 1, 0);
    xa("oor5", 5, 1,    3, 1, 0);
    xa("oor7", 7, 1,    3, 1, 0);
    xa("hs2",  2, 1,   50, 1, 0);
    set_a(-2, 3, -7, 0, 0);
    xa("live", 2, 1,   -7, 1, 0);
    reset = 1'b1; sel_a = 3'd2; in_valid_a = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; in_valid_a = 1'b0;
    check("rst_mid.data", $signed(out_data_a), 0);
    check("rst_mid.valid", out_valid_a, 0);
    check("rst_mid.busy", busy_a, 0);
    xa("after_rst", 0, 1, -2, 1, 0);
    xa("gap1", 2, 0,   -2, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
